// File: rtl/lab2_proc_muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lab2_proc_muldiv_pkg;

  typedef logic [2:0] fn_t;

  localparam fn_t MULDIV_MUL  = 3'd0;
  localparam fn_t MULDIV_DIV  = 3'd1;
  localparam fn_t MULDIV_DIVU = 3'd2;
  localparam fn_t MULDIV_REM  = 3'd3;
  localparam fn_t MULDIV_REMU = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Signed divide/remainder work on magnitudes and need a sign fix-up.
  function automatic logic fn_is_signed_div(input fn_t f);
    return (f == MULDIV_DIV) || (f == MULDIV_REM);
  endfunction

endpackage

// File: rtl/lab2_proc_muldiv_if.sv
// Request/response val/rdy bundle between the X stage and the muldiv unit.
// Latency: n/a (wires only).
// Backpressure: req_rdy stalls the requester, resp_rdy stalls the unit.
interface lab2_proc_muldiv_if
  import lab2_proc_muldiv_pkg::*;
#(
  parameter int p_nbits = 32
) ();

  logic               req_val;
  logic               req_rdy;
  fn_t                req_fn;
  logic [p_nbits-1:0] req_a;
  logic [p_nbits-1:0] req_b;
  logic               resp_val;
  logic               resp_rdy;
  logic [p_nbits-1:0] resp_msg;

  modport master (
    output req_val, req_fn, req_a, req_b, resp_rdy,
    input  req_rdy, resp_val, resp_msg
  );

  modport slave (
    input  req_val, req_fn, req_a, req_b, resp_rdy,
    output req_rdy, resp_val, resp_msg
  );

endinterface

// File: rtl/lab2_proc_muldiv_iter_dpath.sv
// Datapath: operand/accumulator registers, shift-add multiply, restoring divide, result mux.
// Latency: one iteration per step cycle; result mux is combinational.
// Backpressure: none of its own; registers only move on load/step from control.
module lab2_proc_muldiv_iter_dpath
  import lab2_proc_muldiv_pkg::*;
#(
  parameter int p_nbits = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic               msg_en,
  input  fn_t                fn,
  input  logic [p_nbits-1:0] a,
  input  logic [p_nbits-1:0] b,
  output logic [p_nbits-1:0] msg
);

  typedef logic [p_nbits-1:0] word_t;
  typedef logic [p_nbits:0]   wide_t;

  localparam word_t MIN_VAL = {1'b1, {(p_nbits-1){1'b0}}};

  // opa: multiplicand (MUL) or divisor magnitude (DIV/REM)
  // opb: multiplier (MUL) or dividend shifting into quotient (DIV/REM)
  // acc: product accumulator (MUL) or one-bit-wider remainder (DIV/REM)
  fn_t   fn_q;
  word_t a_raw;
  word_t b_raw;
  word_t opa;
  word_t opb;
  wide_t acc;

  wide_t rem_sh;
  logic  rem_ge;
  word_t result;

  function automatic word_t mag(input word_t x);
    return x[p_nbits-1] ? word_t'(-x) : x;
  endfunction

  // Shift {rem,quo} left by one and compare the partial remainder against the divisor.
  always_comb begin
    rem_sh = {acc[p_nbits-1:0], opb[p_nbits-1]};
    rem_ge = (rem_sh >= {1'b0, opa});
  end

  // Operand capture on accept, then one multiply or divide iteration per step.
  always_ff @(posedge clk) begin
    if (reset) begin
      fn_q  <= MULDIV_MUL;
      a_raw <= '0;
      b_raw <= '0;
      opa   <= '0;
      opb   <= '0;
      acc   <= '0;
    end else if (load) begin
      fn_q  <= fn;
      a_raw <= a;
      b_raw <= b;
      acc   <= '0;
      if (fn == MULDIV_MUL) begin
        opa <= a;
        opb <= b;
      end else if (fn_is_signed_div(fn)) begin
        opa <= mag(b);
        opb <= mag(a);
      end else begin
        opa <= b;
        opb <= a;
      end
    end else if (step) begin
      if (fn_q == MULDIV_MUL) begin
        if (opb[0]) acc <= acc + {1'b0, opa};
        opa <= opa << 1;
        opb <= opb >> 1;
      end else begin
        acc <= rem_ge ? (rem_sh - {1'b0, opa}) : rem_sh;
        opb <= {opb[p_nbits-2:0], rem_ge};
      end
    end
  end

  // Sign fix-up and divide-by-zero / signed-overflow overrides on the final values.
  always_comb begin
    logic  b_zero;
    logic  ovf;
    logic  a_neg;
    logic  b_neg;
    word_t quo;
    word_t rem;
    b_zero = (b_raw == '0);
    ovf    = (a_raw == MIN_VAL) && (b_raw == '1);
    a_neg  = a_raw[p_nbits-1];
    b_neg  = b_raw[p_nbits-1];
    quo    = opb;
    rem    = acc[p_nbits-1:0];
    result = '0;
    case (fn_q)
      MULDIV_MUL:  result = acc[p_nbits-1:0];
      MULDIV_DIV:  result = b_zero ? '1 : ovf ? a_raw :
                            (a_neg != b_neg) ? word_t'(-quo) : quo;
      MULDIV_DIVU: result = b_zero ? '1 : quo;
      MULDIV_REM:  result = b_zero ? a_raw : ovf ? '0 :
                            a_neg ? word_t'(-rem) : rem;
      MULDIV_REMU: result = b_zero ? a_raw : rem;
      default:     result = '0;
    endcase
    msg = msg_en ? result : '0;
  end

endmodule

// File: rtl/lab2_proc_muldiv_iter.sv
// Iterative mul/div unit: control FSM (IDLE/CALC/DONE) driving the datapath.
// Latency: accept at edge 0, resp_val in cycle p_nbits+1; one op per p_nbits+2 cycles.
// Backpressure: holds result in DONE until resp_rdy; req_rdy only in IDLE without cancel.
module lab2_proc_muldiv_iter
  import lab2_proc_muldiv_pkg::*;
#(
  parameter int p_nbits = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cancel,
  lab2_proc_muldiv_if.slave        ifc
);

  localparam int CW = $clog2(p_nbits + 1);

  state_t        state;
  logic [CW-1:0] count;
  logic          accept;

  // Handshakes decode the registered state; cancel and reset mask them immediately.
  assign ifc.req_rdy  = !reset && (state == IDLE) && !cancel;
  assign ifc.resp_val = !reset && (state == DONE) && !cancel;
  assign accept       = ifc.req_val && ifc.req_rdy;

  // Control FSM: p_nbits iterations in CALC, hold in DONE until fire, cancel squashes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state <= CALC;
            count <= CW'(p_nbits);
          end
        end
        CALC: begin
          if (cancel) begin
            state <= IDLE;
          end else begin
            count <= count - CW'(1);
            if (count == CW'(1)) state <= DONE;
          end
        end
        DONE: begin
          if (cancel || ifc.resp_rdy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  lab2_proc_muldiv_iter_dpath #(.p_nbits(p_nbits)) dpath (
    .clk    (clk),
    .reset  (reset),
    .load   (accept),
    .step   ((state == CALC) && !cancel),
    .msg_en (!reset),
    .fn     (ifc.req_fn),
    .a      (ifc.req_a),
    .b      (ifc.req_b),
    .msg    (ifc.resp_msg)
  );

endmodule
